// File: rtl/qspi_mem_pkg.sv
// qspi_mem_pkg: opcodes, dummy count and FSM states shared by the QSPI RAM link
package qspi_mem_pkg;
  localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
  localparam logic [7:0] CMD_EXIT_QPI  = 8'hF5;
  localparam logic [7:0] CMD_QRD       = 8'h0B;
  localparam logic [7:0] CMD_QWR       = 8'h38;
  localparam int         RAM_RD_DUMMY  = 4;
  typedef enum logic [2:0] {SPI_CMD, QPI_CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_e;
endpackage

// File: rtl/qspi_ram_array.sv
// qspi_ram_array: byte array, one sync write port (QSPI over backdoor) and one async read port
module qspi_ram_array #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] adr_i,
  input  logic [7:0]           dat_i,
  input  logic                 bd_we_i,
  input  logic [ADDR_BITS-1:0] bd_adr_i,
  input  logic [7:0]           bd_dat_i,
  input  logic [ADDR_BITS-1:0] rd_adr_i,
  output logic [7:0]           rd_dat_o
);
  logic [7:0] mem_q [2**ADDR_BITS];
  // backdoor write first so a same-address QSPI write overrides it
  always_ff @(posedge clk_i) begin
    if (bd_we_i) mem_q[bd_adr_i] <= bd_dat_i;
    if (we_i) mem_q[adr_i] <= dat_i;
  end
  assign rd_dat_o = mem_q[rd_adr_i];
endmodule

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: QSPI pseudo-SRAM responder backed by an on-chip byte array
module qspi_ram_responder
  import qspi_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int DUMMY_CYCLES = RAM_RD_DUMMY
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 cs_in,
  input  logic [3:0]           sd_i,
  output logic [3:0]           sd_o,
  output logic [3:0]           sd_oen_o,
  input  logic                 bd_we_i,
  input  logic [ADDR_BITS-1:0] bd_adr_i,
  input  logic [7:0]           bd_dat_i
);
  // shift register only as wide as the address bits kept; upper address nibbles fall off (aliasing)
  localparam int SH = ADDR_BITS > 11 ? ADDR_BITS - 4 : 8;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  state_e               state_q;
  logic                 qpi_q;
  logic                 wr_q;
  logic [7:0]           cnt_q;
  logic [SH-1:0]        sh_q;
  logic [ADDR_BITS-1:0] adr_q;
  logic [7:0]           rd_byte_q;
  logic [3:0]           nib_q;
  logic [7:0]           spi_cmd;
  logic [7:0]           qpi_cmd;
  logic [SH+3:0]        addr_full;
  logic [ADDR_BITS-1:0] rd_adr;
  logic [7:0]           rd_dat;
  logic                 ram_we;
  assign spi_cmd   = {sh_q[6:0], sd_i[0]};
  assign qpi_cmd   = {sh_q[3:0], sd_i};
  assign addr_full = {sh_q, sd_i};
  // during the burst the next byte is prefetched from adr+1 on the low-nibble cycle
  assign rd_adr    = state_q == RD_DATA ? adr_q + 1'b1 : adr_q;
  assign ram_we    = !cs_in && state_q == WR_DATA && cnt_q[0];
  assign sd_oen_o  = (state_q == RD_DATA && !cs_in) ? 4'hF : 4'h0;
  assign sd_o      = state_q != RD_DATA ? 4'h0 : cnt_q[0] ? rd_byte_q[3:0] : rd_byte_q[7:4];
  qspi_ram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk_i    (clk_i),
    .we_i     (ram_we),
    .adr_i    (adr_q),
    .dat_i    ({nib_q, sd_i}),
    .bd_we_i  (bd_we_i),
    .bd_adr_i (bd_adr_i),
    .bd_dat_i (bd_dat_i),
    .rd_adr_i (rd_adr),
    .rd_dat_o (rd_dat)
  );
  // protocol FSM: command, address, dummy and data phases; cs high restarts in the current mode
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= SPI_CMD;
      qpi_q     <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= '0;
      adr_q     <= '0;
      rd_byte_q <= '0;
      nib_q     <= '0;
    end else if (cs_in) begin
      state_q <= qpi_q ? QPI_CMD : SPI_CMD;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      case (state_q)
        SPI_CMD: begin
          sh_q <= {sh_q[SH-2:0], sd_i[0]};
          if (cnt_q == 8'd7) begin
            cnt_q   <= '0;
            qpi_q   <= qpi_q | (spi_cmd == CMD_ENTER_QPI);
            state_q <= IGNORE;
          end
        end
        QPI_CMD: begin
          sh_q <= {sh_q[SH-5:0], sd_i};
          if (cnt_q == 8'd1) begin
            cnt_q   <= '0;
            wr_q    <= qpi_cmd == CMD_QWR;
            state_q <= (qpi_cmd == CMD_QRD || qpi_cmd == CMD_QWR) ? ADDR : IGNORE;
            if (qpi_cmd == CMD_EXIT_QPI) qpi_q <= 1'b0;
          end
        end
        ADDR: begin
          sh_q <= {sh_q[SH-5:0], sd_i};
          if (cnt_q == 8'd5) begin
            cnt_q   <= '0;
            adr_q   <= addr_full[ADDR_BITS-1:0];
            state_q <= wr_q ? WR_DATA : DUMMY;
          end
        end
        DUMMY: begin
          rd_byte_q <= rd_dat;
          if (cnt_q == DUMMY_LAST) begin
            cnt_q   <= '0;
            state_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (cnt_q[0]) begin
            adr_q     <= adr_q + 1'b1;
            rd_byte_q <= rd_dat;
          end
        end
        WR_DATA: begin
          nib_q <= sd_i;
          if (cnt_q[0]) adr_q <= adr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder: directed self-checking bench for the QSPI RAM responder
module tb_qspi_ram_responder;
  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic        cs_in = 1'b1;
  logic [3:0]  sd_i = 4'h0;
  logic [3:0]  sd_o;
  logic [3:0]  sd_oen_o;
  logic        bd_we_i = 1'b0;
  logic [11:0] bd_adr_i = '0;
  logic [7:0]  bd_dat_i = '0;
  logic [3:0]  last_o;
  logic [3:0]  last_oe;
  logic [31:0] w;
  int          checks = 0;
  int          errors = 0;
  int          bad;

  qspi_ram_responder dut (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .cs_in    (cs_in),
    .sd_i     (sd_i),
    .sd_o     (sd_o),
    .sd_oen_o (sd_oen_o),
    .bd_we_i  (bd_we_i),
    .bd_adr_i (bd_adr_i),
    .bd_dat_i (bd_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] d);
    cs_in = 1'b0;
    sd_i  = d;
    @(negedge clk_i);
    last_o  = sd_o;
    last_oe = sd_oen_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic cs_end();
    cs_in = 1'b1;
    sd_i  = 4'h0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    bd_we_i  = 1'b1;
    bd_adr_i = a;
    bd_dat_i = d;
    @(posedge clk_i);
    #1;
    bd_we_i = 1'b0;
  endtask

  task automatic send_nibs(input logic [31:0] v, input int n, inout int nbad);
    for (int i = 0; i < n; i++) begin
      cyc(v[4*(n-1-i) +: 4]);
      if (last_oe !== 4'h0) nbad++;
    end
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    for (int i = 0; i < 8; i++) cyc({3'b000, b[7-i]});
    cs_end();
  endtask

  task automatic qpi_read(input logic [23:0] a, input int n, output logic [31:0] r);
    int nbad = 0;
    send_nibs({8'h0B, a}, 8, nbad);
    send_nibs(32'h0, 4, nbad);
    r = '0;
    for (int i = 0; i < 2*n; i++) begin
      cyc(4'h0);
      r = {r[27:0], last_o};
      if (last_oe !== 4'hF) nbad++;
    end
    cs_end();
    @(negedge clk_i);
    if (sd_oen_o !== 4'h0) nbad++;
    @(posedge clk_i);
    #1;
    check("rd_oen_window", nbad, 0);
  endtask

  task automatic qpi_write(input logic [23:0] a, input logic [31:0] v, input int n);
    int nbad = 0;
    send_nibs({8'h38, a}, 8, nbad);
    send_nibs(v, n, nbad);
    cs_end();
  endtask

  task automatic probe_ignored(output int nbad);
    nbad = 0;
    send_nibs({8'h0B, 24'h000010}, 8, nbad);
    send_nibs(32'h0, 16, nbad);
    cs_end();
  endtask

  initial begin
    #22;
    check("rst_oen", sd_oen_o, 0);
    check("rst_o", sd_o, 0);
    check("rst_qpi", dut.qpi_q, 0);
    rst_in = 1'b1;
    @(posedge clk_i);
    #1;
    bd_write(12'h010, 8'h11);
    bd_write(12'h011, 8'h22);
    bd_write(12'h012, 8'h33);
    bd_write(12'h013, 8'h44);
    bd_write(12'h020, 8'h5A);
    bd_write(12'h021, 8'h00);
    bd_write(12'h022, 8'hC3);
    bd_write(12'hFFF, 8'h7E);
    bd_write(12'h000, 8'h81);
    bd_write(12'h030, 8'h00);
    bd_write(12'h031, 8'hEE);
    probe_ignored(bad);
    check("spi_mode_read_ignored", bad, 0);
    spi_cmd(8'h35);
    check("qpi_entered", dut.qpi_q, 1);
    qpi_read(24'h000010, 4, w);
    check("word_read", w, 32'h11223344);
    qpi_write(24'h000021, 32'hA5, 2);
    qpi_read(24'h000020, 3, w);
    check("byte_write", w, 32'h005AA5C3);
    qpi_read(24'h000FFF, 2, w);
    check("wrap", w, 32'h00007E81);
    qpi_read(24'h7A5010, 1, w);
    check("alias", w, 32'h00000011);
    qpi_write(24'h000030, 32'h967, 3);
    qpi_read(24'h000030, 2, w);
    check("cs_abort", w, 32'h000096EE);
    bad = 0;
    send_nibs({8'h38, 24'h000040}, 8, bad);
    cyc(4'hB);
    bd_we_i  = 1'b1;
    bd_adr_i = 12'h040;
    bd_dat_i = 8'h33;
    cyc(4'hE);
    bd_we_i = 1'b0;
    cs_end();
    qpi_read(24'h000040, 1, w);
    check("collision_qspi_wins", w, 32'h000000BE);
    bad = 0;
    send_nibs(32'hF5, 2, bad);
    cs_end();
    check("qpi_exited", dut.qpi_q, 0);
    probe_ignored(bad);
    check("exit_read_ignored", bad, 0);
    spi_cmd(8'h35);
    bad = 0;
    send_nibs({8'h0B, 24'h000010}, 8, bad);
    send_nibs(32'h0, 4, bad);
    cyc(4'h0);
    cyc(4'h0);
    check("pre_rst_oen", sd_oen_o, 4'hF);
    rst_in = 1'b0;
    #1;
    check("mid_rst_oen", sd_oen_o, 0);
    check("mid_rst_qpi", dut.qpi_q, 0);
    cs_in = 1'b1;
    @(posedge clk_i);
    #1;
    rst_in = 1'b1;
    @(posedge clk_i);
    #1;
    probe_ignored(bad);
    check("post_rst_read_ignored", bad, 0);
    spi_cmd(8'h35);
    qpi_read(24'h000010, 4, w);
    check("array_preserved", w, 32'h11223344);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
